// File: rtl/esd_sequencer.sv
// Emergency-shutdown sequencer: ordered rail power-up, watchdog kicking while healthy,
// reverse-order rail shutdown on fault/timeout/disarm with a latched cause until acknowledged.
module esd_sequencer #(
    parameter int CLK_HZ   = 24000000,
    parameter int KICK_MS  = 100,
    parameter int STAGE_MS = 10,
    parameter int N_FAULT  = 4,
    parameter int N_STAGE  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               arm,
    input  logic [N_FAULT-1:0] fault_in,
    input  logic [N_FAULT-1:0] fault_mask,
    input  logic               wdt_timeout,
    input  logic               ack,
    output logic               kick,
    output logic [N_STAGE-1:0] stage_en,
    output logic [2:0]         state,
    output logic [N_FAULT:0]   trip_cause,
    output logic               alarm,
    output logic               shutdown_done
);

    localparam int KICK_RAW  = CLK_HZ / 1000 * KICK_MS;
    localparam int STAGE_RAW = CLK_HZ / 1000 * STAGE_MS;
    localparam int KICK_CYC  = (KICK_RAW < 4) ? 4 : KICK_RAW;
    localparam int STAGE_CYC = (STAGE_RAW < 1) ? 1 : STAGE_RAW;
    localparam int KW        = $clog2(KICK_CYC) + 1;
    localparam int SW        = $clog2(STAGE_CYC) + 1;

    localparam logic [N_STAGE-1:0] EN_LSB   = N_STAGE'(1);
    localparam logic [N_STAGE-1:0] EN_ALL   = '1;
    localparam logic [N_STAGE-1:0] EN_NONE  = '0;
    localparam logic [SW-1:0]      SCNT_TOP = SW'(STAGE_CYC - 1);
    localparam logic [KW-1:0]      KCNT_TOP = KW'(KICK_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMING  = 3'd1,
        S_RUN     = 3'd2,
        S_TRIP    = 3'd3,
        S_SEQ     = 3'd4,
        S_LATCHED = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [N_FAULT-1:0] sync1_q, sync2_q;
    logic [N_FAULT-1:0] f_act_s;
    logic               fault_s;
    logic [N_STAGE-1:0] en_q, en_d;
    logic [N_STAGE-1:0] en_clr_s;
    logic [SW-1:0]      scnt_q, scnt_d, scnt_nxt_s;
    logic [KW-1:0]      kcnt_q, kcnt_d;
    logic               kick_q, kick_d;
    logic [N_FAULT:0]   cause_q, cause_d;
    logic               alarm_q, alarm_d;
    logic               done_q, done_d;
    logic               active_d_s;

    // Clears the most significant set bit, leaving lower rails untouched.
    function automatic logic [N_STAGE-1:0] clr_top(input logic [N_STAGE-1:0] v);
        logic [N_STAGE-1:0] r;
        logic               found;
        r     = v;
        found = 1'b0;
        for (int i = N_STAGE - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                r[i]  = 1'b0;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return r;
    endfunction

    assign f_act_s  = sync2_q & ~fault_mask;
    assign fault_s  = |f_act_s;
    assign en_clr_s = clr_top(en_q);

    // Fault input synchroniser.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= fault_in;
            sync2_q <= sync1_q;
        end
    end

    // Next-state, rail sequencing and cause capture.
    always_comb begin
        state_d    = state_q;
        en_d       = en_q;
        scnt_nxt_s = scnt_q;
        cause_d    = cause_q;
        alarm_d    = alarm_q;
        case (state_q)
            S_IDLE: begin
                en_d = EN_NONE;
                if (arm && !fault_s) state_d = S_ARMING;
                else                 state_d = S_IDLE;
            end
            S_ARMING: begin
                if (fault_s || wdt_timeout) begin
                    state_d = S_TRIP;
                    cause_d = {wdt_timeout, f_act_s};
                    alarm_d = 1'b1;
                end else if (!arm) begin
                    state_d = S_SEQ;
                end else if (scnt_q != '0) begin
                    scnt_nxt_s = scnt_q - SW'(1);
                end else if (en_q == EN_ALL) begin
                    state_d = S_RUN;
                end else begin
                    en_d       = (en_q << 1) | EN_LSB;
                    scnt_nxt_s = SCNT_TOP;
                end
            end
            S_RUN: begin
                en_d = EN_ALL;
                if (fault_s || wdt_timeout) begin
                    state_d = S_TRIP;
                    cause_d = {wdt_timeout, f_act_s};
                    alarm_d = 1'b1;
                end else if (!arm) begin
                    state_d = S_SEQ;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_TRIP: begin
                state_d = S_SEQ;
            end
            S_SEQ: begin
                if (en_q == EN_NONE) begin
                    state_d = S_LATCHED;
                end else if (scnt_q != '0) begin
                    scnt_nxt_s = scnt_q - SW'(1);
                end else begin
                    en_d       = en_clr_s;
                    scnt_nxt_s = SCNT_TOP;
                    if (en_clr_s == EN_NONE) state_d = S_LATCHED;
                    else                     state_d = S_SEQ;
                end
            end
            S_LATCHED: begin
                en_d = EN_NONE;
                if (ack && !arm && !fault_s) begin
                    state_d = S_IDLE;
                    cause_d = '0;
                    alarm_d = 1'b0;
                end else begin
                    state_d = S_LATCHED;
                end
            end
            default: begin
                // Corrupted state register: force a shutdown with an unmistakable cause.
                state_d = S_TRIP;
                cause_d = '1;
                alarm_d = 1'b1;
            end
        endcase

        scnt_d = (state_d != state_q) ? '0 : scnt_nxt_s;

        active_d_s = (state_d == S_ARMING) || (state_d == S_RUN);
        if (state_d == S_ARMING && state_q != S_ARMING) begin
            kcnt_d = '0;
        end else if (active_d_s) begin
            kcnt_d = (kcnt_q == KCNT_TOP) ? '0 : kcnt_q + KW'(1);
        end else begin
            kcnt_d = '0;
        end
        kick_d = active_d_s && (kcnt_d < KW'(2));
        done_d = (state_d == S_LATCHED);
    end

    // State and output registers; reset forces every rail and flag safe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            en_q    <= '0;
            scnt_q  <= '0;
            kcnt_q  <= '0;
            kick_q  <= 1'b0;
            cause_q <= '0;
            alarm_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            scnt_q  <= scnt_d;
            kcnt_q  <= kcnt_d;
            kick_q  <= kick_d;
            cause_q <= cause_d;
            alarm_q <= alarm_d;
            done_q  <= done_d;
        end
    end

    assign state         = state_q;
    assign stage_en      = en_q;
    assign kick          = kick_q;
    assign trip_cause    = cause_q;
    assign alarm         = alarm_q;
    assign shutdown_done = done_q;

endmodule

// File: doc/esd_sequencer.md
Name: esd_sequencer

Overview:
Top-level emergency-shutdown controller for the watchdog-protected subsystem. Powers up N_STAGE enable rails in order and keeps the external watchdog alive with periodic kick pulses while the system is healthy. On a fault, a watchdog timeout or an operator disarm, it takes the rails down in reverse order and latches the cause until it is acknowledged. Sits between the plant fault inputs, the watchdog timer and the rail-enable drivers.

Parameters:
CLK_HZ, 24000000, system clock frequency in Hz
KICK_MS, 100, kick period in ms; must be shorter than the watchdog TIMEOUT_MS
STAGE_MS, 10, delay between successive rail enables/disables in ms
N_FAULT, 4, number of external fault inputs
N_STAGE, 3, number of sequenced enable rails

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
arm  input  1  level; high requests power-up/run, low requests orderly shutdown
fault_in  input  N_FAULT  asynchronous active-high faults; synchronised internally through 2 FFs
fault_mask  input  N_FAULT  1 = ignore the corresponding fault (quasi-static)
wdt_timeout  input  1  timeout output of the watchdog
ack  input  1  operator acknowledge; level-sampled
kick  output  1  kick to the watchdog
stage_en  output  N_STAGE  rail enables; bit 0 comes up first and goes down last
state  output  3  current state encoding
trip_cause  output  N_FAULT+1  bit i = fault i; bit N_FAULT = watchdog; all zero = orderly shutdown
alarm  output  1  high from TRIP until LATCHED exits
shutdown_done  output  1  high in LATCHED

Behaviour:
- Derived constants: KICK_CYC = max(4, CLK_HZ/1000*KICK_MS). STAGE_CYC = max(1, CLK_HZ/1000*STAGE_MS). Counter widths use ceil-log2 plus 1.
- Reset (async, rst_n low): state=IDLE, stage_en=0, kick=0, trip_cause=0, alarm=0, shutdown_done=0, counters=0. Outputs go safe immediately, including mid-sequence.
- f_act = sync(fault_in) & ~fault_mask. "Fault" means |f_act.
- State encodings: IDLE=0, ARMING=1, RUN=2, TRIP=3, SEQ=4, LATCHED=5. Unused codes go to TRIP with cause = all ones.
- IDLE: stage_en=0, kick=0. Goes to ARMING when arm=1 and no fault.
- ARMING:
  - Sets stage_en[0] in the first cycle after entry, then the next bit every STAGE_CYC cycles.
  - Goes to RUN STAGE_CYC cycles after stage_en is all ones.
  - arm=0 goes to SEQ as an orderly shutdown.
- RUN: stage_en stays all ones. arm=0 goes to SEQ with trip_cause=0 and alarm=0.
- Kick:
  - Active in ARMING and RUN.
  - The period counter restarts on ARMING entry.
  - kick=1 for counter values 0 and 1 (a 2-cycle pulse) every KICK_CYC cycles.
  - The counter is not reset on the ARMING to RUN transition.
  - kick=0 in all other states.
- Trip detection (ARMING or RUN only):
  - Fault or wdt_timeout goes to TRIP on the next edge.
  - Fault/trip has priority over arm=0 in the same cycle.
- TRIP (1 cycle):
  - Captures trip_cause = {wdt_timeout, f_act} as seen in the triggering cycle. Simultaneous sources are all captured.
  - Sets alarm=1, then goes to SEQ.
- SEQ:
  - Clears the highest set stage_en bit in its first cycle, then the next bit every STAGE_CYC cycles.
  - When stage_en reaches 0, goes to LATCHED.
  - trip_cause is frozen; later faults and timeouts are ignored; arm is ignored.
  - If entered from ARMING with stages partially up, only the set bits are cleared, same spacing. If none are set, goes to LATCHED immediately.
- LATCHED:
  - shutdown_done=1 and stage_en=0.
  - Goes to IDLE when ack=1, arm=0 and no fault, all in the same cycle.
  - On exit: trip_cause, alarm and shutdown_done clear.
  - ack while arm=1 or while a fault is active is ignored.
- wdt_timeout is ignored in IDLE, SEQ and LATCHED.

Test Plan:
1. CLK_HZ=1000, STAGE_MS=3, KICK_MS=8, N_STAGE=3. Raise arm → stage_en goes 001, 011, 111 at 3-cycle spacing, then RUN. kick is high for 2 of every 8 cycles starting at ARMING entry.
2. In RUN, pulse fault_in[2] for 5 cycles → 2-FF sync, then TRIP, trip_cause=0b00100, alarm=1. stage_en goes 011, 001, 000 at 3-cycle spacing, then shutdown_done=1 and kick=0.
3. In RUN, assert wdt_timeout and fault_in[0] in the same cycle → trip_cause=0b10001. Drop arm during SEQ → no effect on the sequence.
4. In RUN, drop arm → orderly shutdown, trip_cause=0, alarm=0, LATCHED. ack with arm=1 → stays LATCHED. ack with arm=0 → IDLE, outputs cleared.
5. Set fault_mask[1]=1 and assert fault_in[1] in RUN → no trip. Assert fault_in[1] during ARMING after stage 1 → SEQ clears only 001 to 000.
6. Drive rst_n low mid-SEQ → stage_en, kick and alarm are 0 asynchronously before the next clock edge; state=IDLE after release.
